baud_gen_frac: RTL and testbench

Fractional, runtime-programmable baud/oversample tick generator for the UART; successor to the fixed-divisor generator. Produces an oversample strobe whose average period is div_int + div_frac/2^FRAC_W clocks, a per-bit baud strobe, and a mid-bit sample strobe. A resync input lets the RX path align bit phase to a detected start edge. Sits between the register block (divisor writes) and the UART TX/RX engines.

---
 rtl/baud_gen_frac.sv | 102 ++++++++++
 tb/tb_baud_gen_frac.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/baud_gen_frac.sv
// Fractional, runtime-programmable oversample/baud tick generator.
// Average oversample period is div_int + div_frac/2^FRAC_W clocks; a divisor write is applied at an interval boundary.
module baud_gen_frac #(
    parameter int DIV_W        = 16,
    parameter int FRAC_W       = 4,
    parameter int OVS          = 16,
    parameter int RST_DIV_INT  = 54,
    parameter int RST_DIV_FRAC = 4,
    localparam int PH_W        = $clog2(OVS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              resync,
    input  logic              cfg_we,
    input  logic [DIV_W-1:0]  cfg_div_int,
    input  logic [FRAC_W-1:0] cfg_div_frac,
    output logic              cfg_pending,
    output logic              tick_ovs,
    output logic              baud_tick,
    output logic              mid_tick,
    output logic [PH_W-1:0]   phase
);

    logic [DIV_W-1:0]  div_int, sh_int, new_int;
    logic [FRAC_W-1:0] div_frac, sh_frac, new_frac, acc;
    logic              carry;
    logic [DIV_W:0]    cnt, period;
    logic [FRAC_W:0]   frac_sum;
    logic [PH_W-1:0]   phase_next;
    logic              halted, last, do_apply;

    // A write in the same cycle as an apply point wins over the older shadow value.
    always_comb begin
        new_int    = cfg_we ? cfg_div_int  : sh_int;
        new_frac   = cfg_we ? cfg_div_frac : sh_frac;
        do_apply   = cfg_we || cfg_pending;
        period     = {1'b0, div_int} + {{DIV_W{1'b0}}, carry};
        frac_sum   = {1'b0, acc} + {1'b0, div_frac};
        halted     = (div_int == '0);
        last       = (cnt == period - {{DIV_W{1'b0}}, 1'b1});
        phase_next = (phase == PH_W'(OVS - 1)) ? '0 : phase + {{(PH_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_int     <= DIV_W'(RST_DIV_INT);
            div_frac    <= FRAC_W'(RST_DIV_FRAC);
            sh_int      <= DIV_W'(RST_DIV_INT);
            sh_frac     <= FRAC_W'(RST_DIV_FRAC);
            cfg_pending <= 1'b0;
            cnt         <= '0;
            acc         <= '0;
            carry       <= 1'b0;
            phase       <= '0;
            tick_ovs    <= 1'b0;
            baud_tick   <= 1'b0;
            mid_tick    <= 1'b0;
        end else begin
            tick_ovs  <= 1'b0;
            baud_tick <= 1'b0;
            mid_tick  <= 1'b0;
            if (cfg_we) begin
                sh_int  <= cfg_div_int;
                sh_frac <= cfg_div_frac;
            end
            // Resync and a halted divisor both restart timing from zero and take any new divisor at once.
            if (resync || halted) begin
                cnt   <= '0;
                acc   <= '0;
                carry <= 1'b0;
                phase <= '0;
                if (do_apply) begin
                    div_int  <= new_int;
                    div_frac <= new_frac;
                end
                cfg_pending <= 1'b0;
            end else if (enable) begin
                if (last) begin
                    tick_ovs  <= 1'b1;
                    baud_tick <= (phase == PH_W'(OVS - 1));
                    mid_tick  <= (phase == PH_W'(OVS / 2 - 1));
                    cnt       <= '0;
                    acc       <= frac_sum[FRAC_W-1:0];
                    carry     <= frac_sum[FRAC_W];
                    phase     <= phase_next;
                    if (do_apply) begin
                        div_int  <= new_int;
                        div_frac <= new_frac;
                    end
                    cfg_pending <= 1'b0;
                end else begin
                    cnt <= cnt + {{DIV_W{1'b0}}, 1'b1};
                    if (cfg_we) cfg_pending <= 1'b1;
                end
            end else if (cfg_we) begin
                cfg_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_baud_gen_frac.sv
// Directed bench for baud_gen_frac: fractional spacing, strobes, divisor writes, resync, enable and reset.
// A second instance with OVS=4 shares all inputs and is checked only in the short-bit scenario.
module tb_baud_gen_frac;

    logic        clk = 1'b0;
    logic        reset, enable, resync, cfg_we;
    logic [15:0] cfg_div_int;
    logic [3:0]  cfg_div_frac;
    logic        cfg_pending, tick_ovs, baud_tick, mid_tick;
    logic [3:0]  phase;
    logic        cfg_pending4, tick_ovs4, baud_tick4, mid_tick4;
    logic [1:0]  phase4;

    int checks = 0;
    int errors = 0;

    baud_gen_frac dut (
        .clk(clk), .reset(reset), .enable(enable), .resync(resync), .cfg_we(cfg_we),
        .cfg_div_int(cfg_div_int), .cfg_div_frac(cfg_div_frac), .cfg_pending(cfg_pending),
        .tick_ovs(tick_ovs), .baud_tick(baud_tick), .mid_tick(mid_tick), .phase(phase)
    );

    baud_gen_frac #(.OVS(4)) dut4 (
        .clk(clk), .reset(reset), .enable(enable), .resync(resync), .cfg_we(cfg_we),
        .cfg_div_int(cfg_div_int), .cfg_div_frac(cfg_div_frac), .cfg_pending(cfg_pending4),
        .tick_ovs(tick_ovs4), .baud_tick(baud_tick4), .mid_tick(mid_tick4), .phase(phase4)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // One rising edge, then settle before sampling outputs.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Resync together with a divisor write: new divisor applies at once, edge numbering restarts.
    task automatic apply_stimulus(input logic [15:0] d_int, input logic [3:0] d_frac);
        cfg_div_int  = d_int;
        cfg_div_frac = d_frac;
        cfg_we       = 1'b1;
        resync       = 1'b1;
        step();
        cfg_we = 1'b0;
        resync = 1'b0;
    endtask

    int n, e1, e8, e16, m8, b16, mids, bauds, idx;
    int frac_edges[16] = '{3, 6, 10, 13, 17, 20, 24, 27, 31, 34, 38, 41, 45, 48, 52, 55};
    int ph4_expect[4]  = '{1, 2, 3, 0};

    initial begin
        reset = 1'b1; enable = 1'b1; resync = 1'b0; cfg_we = 1'b0;
        cfg_div_int = 16'd0; cfg_div_frac = 4'd0;
        repeat (3) step();
        check_output("rst_tick",    int'(tick_ovs),    0);
        check_output("rst_baud",    int'(baud_tick),   0);
        check_output("rst_mid",     int'(mid_tick),    0);
        check_output("rst_phase",   int'(phase),       0);
        check_output("rst_pending", int'(cfg_pending), 0);
        reset = 1'b0;

        // Reset divisor 54.25, OVS=16.
        n = 0; e1 = 0; e8 = 0; e16 = 0; m8 = 0; b16 = 0; mids = 0; bauds = 0;
        for (int k = 1; k <= 868; k++) begin
            step();
            if (tick_ovs) begin
                n++;
                if (n == 1) e1 = k;
                if (n == 8) begin e8 = k; m8 = int'(mid_tick); end
                if (n == 16) begin e16 = k; b16 = int'(baud_tick); end
            end
            if (mid_tick) mids++;
            if (baud_tick) bauds++;
        end
        check_output("def_ticks_in_868", n, 16);
        check_output("def_first_edge", e1, 54);
        check_output("def_tick8_edge", e8, 433);
        check_output("def_tick16_edge", e16, 867);
        check_output("def_mid_on_8th", m8, 1);
        check_output("def_baud_on_16th", b16, 1);
        check_output("def_mid_count", mids, 1);
        check_output("def_baud_count", bauds, 1);
        check_output("def_phase_end", int'(phase), 0);

        // OVS=4 instance, divisor 4.0 applied together with resync.
        apply_stimulus(16'd4, 4'd0);
        check_output("rs_cfg_tick", int'(tick_ovs4), 0);
        check_output("rs_cfg_phase", int'(phase4), 0);
        check_output("rs_cfg_pending", int'(cfg_pending4), 0);
        for (int k = 1; k <= 16; k++) begin
            step();
            check_output($sformatf("ovs4_tick_e%0d", k), int'(tick_ovs4), int'(k % 4 == 0));
            check_output($sformatf("ovs4_mid_e%0d", k), int'(mid_tick4), int'(k == 8));
            check_output($sformatf("ovs4_baud_e%0d", k), int'(baud_tick4), int'(k == 16));
            if (k % 4 == 0)
                check_output($sformatf("ovs4_phase_e%0d", k), int'(phase4), ph4_expect[k/4 - 1]);
        end

        // Fractional divisor 3 + 8/16.
        apply_stimulus(16'd3, 4'd8);
        n = 0; idx = 0;
        for (int k = 1; k <= 56; k++) begin
            step();
            if (tick_ovs) n++;
            check_output($sformatf("frac_tick_e%0d", k), int'(tick_ovs),
                         int'(idx < 16 && frac_edges[idx] == k));
            if (idx < 16 && frac_edges[idx] == k) idx++;
            check_output($sformatf("frac_mid_e%0d", k), int'(mid_tick), int'(k == 27));
            check_output($sformatf("frac_baud_e%0d", k), int'(baud_tick), int'(k == 55));
        end
        check_output("frac_ticks_in_56", n, 16);

        // Divisor write 5 -> 7 in the middle of an interval.
        apply_stimulus(16'd5, 4'd0);
        step();
        cfg_div_int = 16'd7; cfg_we = 1'b1;
        step();
        cfg_we = 1'b0;
        check_output("wr_pending_e2", int'(cfg_pending), 1);
        for (int k = 3; k <= 12; k++) begin
            step();
            check_output($sformatf("wr_tick_e%0d", k), int'(tick_ovs), int'(k == 5 || k == 12));
            check_output($sformatf("wr_pending_e%0d", k), int'(cfg_pending), int'(k < 5));
        end

        // Halted generator, then a write starts it immediately.
        apply_stimulus(16'd0, 4'd0);
        for (int k = 1; k <= 5; k++) begin
            step();
            check_output($sformatf("halt_tick_e%0d", k), int'(tick_ovs), 0);
        end
        check_output("halt_phase", int'(phase), 0);
        cfg_div_int = 16'd3; cfg_we = 1'b1;
        step();
        cfg_we = 1'b0;
        check_output("halt_wr_pending", int'(cfg_pending), 0);
        for (int k = 1; k <= 6; k++) begin
            step();
            check_output($sformatf("halt_wr_tick_e%0d", k), int'(tick_ovs), int'(k == 3 || k == 6));
        end

        // Resync sampled on the edge where a tick is due.
        apply_stimulus(16'd5, 4'd0);
        for (int k = 1; k <= 9; k++) step();
        check_output("pre_rs_phase", int'(phase), 1);
        resync = 1'b1;
        step();
        resync = 1'b0;
        check_output("rs_suppressed_tick", int'(tick_ovs), 0);
        check_output("rs_phase", int'(phase), 0);
        for (int k = 1; k <= 40; k++) begin
            step();
            check_output($sformatf("rs_tick_e%0d", k), int'(tick_ovs), int'(k % 5 == 0));
            check_output($sformatf("rs_mid_e%0d", k), int'(mid_tick), int'(k == 40));
        end
        check_output("rs_phase_after8", int'(phase), 8);

        // Enable low for 10 cycles mid-interval.
        apply_stimulus(16'd5, 4'd0);
        step(); step();
        enable = 1'b0;
        for (int k = 3; k <= 12; k++) begin
            step();
            check_output($sformatf("dis_tick_e%0d", k), int'(tick_ovs | mid_tick | baud_tick), 0);
        end
        enable = 1'b1;
        for (int k = 13; k <= 15; k++) begin
            step();
            check_output($sformatf("en_tick_e%0d", k), int'(tick_ovs), int'(k == 15));
        end

        // Reset pulse mid-bit with a write pending.
        cfg_div_int = 16'd9; cfg_we = 1'b1;
        step();
        cfg_we = 1'b0;
        check_output("pre_rst_pending", int'(cfg_pending), 1);
        check_output("pre_rst_phase", int'(phase), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_output("midrst_tick", int'(tick_ovs | baud_tick | mid_tick), 0);
        check_output("midrst_phase", int'(phase), 0);
        check_output("midrst_pending", int'(cfg_pending), 0);
        for (int k = 1; k <= 54; k++) begin
            step();
            check_output($sformatf("postrst_tick_e%0d", k), int'(tick_ovs), int'(k == 54));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
